wb_bus_arb_tmo: RTL and testbench

Parametrised shared Wishbone bus for M masters and S slaves, successor to the single-arbiter ProNoC shared bus. It adds:
- selectable round-robin or fixed-priority arbitration with grant hand-off in the same cycle;
- a per-transfer watchdog that terminates hung slave accesses with ERR;
- decode-error termination when no slave is selected;
- a registered error-report interface.

It sits between tile masters (CPU, DMA, JTAG) and the slave set, with the address decoder external.

---
 rtl/wb_bus_pkg.sv | 23 ++
 rtl/wb_bus_arb.sv | 46 ++++
 rtl/wb_bus_arb_tmo.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_bus_arb_tmo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// Shared definitions for the multi-master Wishbone bus with watchdog.
package wb_bus_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TERM = 2'd2
    } bus_state_e;

    // ceil(log2(v)), floored at 1 so the result can always size a vector
    function automatic int log2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_bus_arb.sv
// Next-grant arbiter: round-robin with rotating pointer or fixed lowest-index priority.
module wb_bus_arb
    import wb_bus_pkg::*;
#(
    parameter int M        = 4,
    parameter int ARB_MODE = ARB_RR
)(
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] req,
    input  logic         take,      // the top registers gnt_nxt at this edge
    output logic [M-1:0] gnt_nxt
);
    localparam int PW = log2(M);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx;
    logic          found;
    int            idx;

    // scan requesters starting at the pointer (RR) or at index 0 (fixed)
    always_comb begin
        gnt_nxt = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < M; i++) begin
            if (ARB_MODE == ARB_FIXED) idx = i;
            else                       idx = (int'(ptr_q) + i) % M;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = PW'(idx);
            end
        end
        if (found) gnt_nxt[win_idx] = 1'b1;
        ptr_d = ptr_q;
        if (take && found) ptr_d = PW'((int'(win_idx) + 1) % M);
    end

    // priority pointer: the master after the last winner goes first next time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/wb_bus_arb_tmo.sv
// Shared Wishbone bus: M masters, S slaves, arbitration, watchdog and error reporting.
module wb_bus_arb_tmo
    import wb_bus_pkg::*;
#(
    parameter int M        = 4,
    parameter int S        = 4,
    parameter int Dw       = 32,
    parameter int Aw       = 32,
    parameter int SELw     = 4,
    parameter int TAGw     = 3,
    parameter int CTIw     = 3,
    parameter int BTEw     = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int TMO_CYC  = 255
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [Aw*M-1:0]      m_adr_i_all,
    input  logic [Dw*M-1:0]      m_dat_i_all,
    input  logic [SELw*M-1:0]    m_sel_i_all,
    input  logic [TAGw*M-1:0]    m_tag_i_all,
    input  logic [CTIw*M-1:0]    m_cti_i_all,
    input  logic [BTEw*M-1:0]    m_bte_i_all,
    input  logic [M-1:0]         m_we_i_all,
    input  logic [M-1:0]         m_stb_i_all,
    input  logic [M-1:0]         m_cyc_i_all,
    output logic [Dw*M-1:0]      m_dat_o_all,
    output logic [M-1:0]         m_ack_o_all,
    output logic [M-1:0]         m_err_o_all,
    output logic [M-1:0]         m_rty_o_all,
    output logic [Aw*S-1:0]      s_adr_o_all,
    output logic [Dw*S-1:0]      s_dat_o_all,
    output logic [SELw*S-1:0]    s_sel_o_all,
    output logic [TAGw*S-1:0]    s_tag_o_all,
    output logic [CTIw*S-1:0]    s_cti_o_all,
    output logic [BTEw*S-1:0]    s_bte_o_all,
    output logic [S-1:0]         s_we_o_all,
    output logic [S-1:0]         s_cyc_o_all,
    output logic [S-1:0]         s_stb_o_all,
    input  logic [Dw*S-1:0]      s_dat_i_all,
    input  logic [S-1:0]         s_ack_i_all,
    input  logic [S-1:0]         s_err_i_all,
    input  logic [S-1:0]         s_rty_i_all,
    output logic [Aw-1:0]        m_grant_addr,
    input  logic [S-1:0]         s_sel_one_hot,
    output logic                 bus_err_o,
    output logic                 bus_err_tmo_o,
    output logic [log2(M)-1:0]   bus_err_mst_o,
    output logic [Aw-1:0]        bus_err_adr_o
);
    localparam int MW    = log2(M);
    localparam int CW    = log2(TMO_CYC + 1);
    localparam bit WD_EN = (TMO_CYC != 0);

    bus_state_e     state_q, state_d;
    logic [M-1:0]   grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d, err_tmo_q, err_tmo_d;
    logic [MW-1:0]  err_mst_q, err_mst_d;
    logic [Aw-1:0]  err_adr_q, err_adr_d;

    logic [M-1:0]   arb_gnt, rel_grant;
    bus_state_e     rel_state;
    logic           take, any_cyc;
    logic [Aw-1:0]  g_adr;
    logic [Dw-1:0]  g_dat, rdat, m_rdat;
    logic [SELw-1:0] g_sel;
    logic [TAGw-1:0] g_tag;
    logic [CTIw-1:0] g_cti;
    logic [BTEw-1:0] g_bte;
    logic [MW-1:0]  g_idx;
    logic           g_we, g_cyc, g_stb, own, req_act, dec_err;
    logic           any_ack, any_err, any_rty, slv_resp, tmo_hit;
    logic           err_evt, err_tmo;

    generate
        if (M == 1) begin : g_bypass
            assign arb_gnt = m_cyc_i_all;
        end else begin : g_arb
            wb_bus_arb #(.M(M), .ARB_MODE(ARB_MODE)) u_arb (
                .clk     (clk),
                .reset   (reset),
                .req     (m_cyc_i_all),
                .take    (take),
                .gnt_nxt (arb_gnt)
            );
        end
    endgenerate

    // one-hot mux of the granted master's request; all zero while grant is 0
    always_comb begin
        g_adr = '0; g_dat = '0; g_sel = '0; g_tag = '0; g_cti = '0; g_bte = '0;
        g_idx = '0;
        for (int i = 0; i < M; i++) begin
            if (grant_q[i]) begin
                g_adr |= m_adr_i_all[i*Aw +: Aw];
                g_dat |= m_dat_i_all[i*Dw +: Dw];
                g_sel |= m_sel_i_all[i*SELw +: SELw];
                g_tag |= m_tag_i_all[i*TAGw +: TAGw];
                g_cti |= m_cti_i_all[i*CTIw +: CTIw];
                g_bte |= m_bte_i_all[i*BTEw +: BTEw];
                g_idx |= MW'(i);
            end
        end
    end

    // read data comes from whichever slave the decoder picked
    always_comb begin
        rdat = '0;
        for (int j = 0; j < S; j++) begin
            if (s_sel_one_hot[j]) rdat |= s_dat_i_all[j*Dw +: Dw];
        end
    end

    assign g_we     = |(grant_q & m_we_i_all);
    assign g_cyc    = |(grant_q & m_cyc_i_all);
    assign g_stb    = |(grant_q & m_stb_i_all);
    assign own      = (state_q == OWN);
    assign req_act  = own && g_cyc && g_stb;
    assign dec_err  = req_act && (s_sel_one_hot == '0);
    assign any_ack  = |s_ack_i_all;
    assign any_err  = |s_err_i_all;
    assign any_rty  = |s_rty_i_all;
    // slave responses only count while the bus is owned; TERM swallows them
    assign slv_resp = own && (any_ack || any_err || any_rty);
    assign tmo_hit  = WD_EN && req_act && !slv_resp && !dec_err && (cnt_q == CW'(TMO_CYC));

    assign m_rdat       = own ? rdat : '0;
    assign m_dat_o_all  = {M{m_rdat}};
    assign m_ack_o_all  = grant_q & {M{own && any_ack}};
    assign m_rty_o_all  = grant_q & {M{own && any_rty}};
    assign m_err_o_all  = grant_q & {M{(own && any_err) || dec_err || (state_q == TERM)}};
    assign s_adr_o_all  = {S{g_adr}};
    assign s_dat_o_all  = {S{g_dat}};
    assign s_sel_o_all  = {S{g_sel}};
    assign s_tag_o_all  = {S{g_tag}};
    assign s_cti_o_all  = {S{g_cti}};
    assign s_bte_o_all  = {S{g_bte}};
    assign s_we_o_all   = {S{g_we}};
    assign s_cyc_o_all  = {S{own && g_cyc}};
    assign s_stb_o_all  = s_sel_one_hot & {S{req_act}};
    assign m_grant_addr = g_adr;

    assign any_cyc   = |m_cyc_i_all;
    assign rel_grant = any_cyc ? arb_gnt : '0;
    assign rel_state = any_cyc ? OWN : IDLE;

    // bus FSM: grant/lock/hand-off plus the per-transfer watchdog counter
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        err_evt = 1'b0;
        err_tmo = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_cyc) begin
                    state_d = OWN;
                    grant_d = arb_gnt;
                    take    = 1'b1;
                end
            end
            OWN: begin
                if (!g_cyc) begin
                    // hand-off to the next requester at this same edge
                    state_d = rel_state;
                    grant_d = rel_grant;
                    take    = any_cyc;
                    cnt_d   = '0;
                end else if (dec_err) begin
                    cnt_d   = '0;
                    err_evt = 1'b1;
                end else if (!g_stb || slv_resp) begin
                    cnt_d = '0;
                end else if (tmo_hit) begin
                    cnt_d   = '0;
                    state_d = TERM;
                    err_evt = 1'b1;
                    err_tmo = 1'b1;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TERM: begin
                cnt_d = '0;
                if (g_cyc) begin
                    state_d = OWN;
                end else begin
                    state_d = rel_state;
                    grant_d = rel_grant;
                    take    = any_cyc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // error report captured at the edge ending the detection cycle, so a
    // timeout is visible during TERM and a decode error the cycle after
    always_comb begin
        err_d     = 1'b0;
        err_tmo_d = err_tmo_q;
        err_mst_d = err_mst_q;
        err_adr_d = err_adr_q;
        if (err_evt) begin
            err_d     = 1'b1;
            err_tmo_d = err_tmo;
            err_mst_d = g_idx;
            err_adr_d = g_adr;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_tmo_q <= 1'b0;
            err_mst_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_tmo_q <= err_tmo_d;
            err_mst_q <= err_mst_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign bus_err_o     = err_q;
    assign bus_err_tmo_o = err_tmo_q;
    assign bus_err_mst_o = err_mst_q;
    assign bus_err_adr_o = err_adr_q;

endmodule

// File: tb/tb_wb_bus_arb_tmo.sv
// Bench: table of per-cycle vectors through a scoreboard queue, then hand-written
// sequences for timeout, fixed priority vs round-robin, and mid-transfer reset.
module tb_wb_bus_arb_tmo;
    import wb_bus_pkg::*;

    localparam int M = 4, S = 4, Dw = 32, Aw = 32, SELw = 4, TAGw = 3, CTIw = 3, BTEw = 2;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [Aw*M-1:0]   m_adr;
    logic [Dw*M-1:0]   m_dat;
    logic [SELw*M-1:0] m_sel;
    logic [TAGw*M-1:0] m_tag;
    logic [CTIw*M-1:0] m_cti;
    logic [BTEw*M-1:0] m_bte;
    logic [M-1:0]      m_we, m_stb, m_cyc;
    logic [Dw*S-1:0]   s_dat_i;
    logic [S-1:0]      s_ack, s_err, s_rty, s_sel;

    // round-robin instance outputs
    logic [Dw*M-1:0] r_m_dat; logic [M-1:0] r_m_ack, r_m_err, r_m_rty;
    logic [Aw*S-1:0] r_s_adr; logic [Dw*S-1:0] r_s_dat; logic [SELw*S-1:0] r_s_sel;
    logic [TAGw*S-1:0] r_s_tag; logic [CTIw*S-1:0] r_s_cti; logic [BTEw*S-1:0] r_s_bte;
    logic [S-1:0] r_s_we, r_s_cyc, r_s_stb; logic [Aw-1:0] r_gadr, r_eadr;
    logic r_berr, r_btmo; logic [1:0] r_emst;
    // fixed-priority instance outputs
    logic [Dw*M-1:0] f_m_dat; logic [M-1:0] f_m_ack, f_m_err, f_m_rty;
    logic [Aw*S-1:0] f_s_adr; logic [Dw*S-1:0] f_s_dat; logic [SELw*S-1:0] f_s_sel;
    logic [TAGw*S-1:0] f_s_tag; logic [CTIw*S-1:0] f_s_cti; logic [BTEw*S-1:0] f_s_bte;
    logic [S-1:0] f_s_we, f_s_cyc, f_s_stb; logic [Aw-1:0] f_gadr, f_eadr;
    logic f_berr, f_btmo; logic [1:0] f_emst;

    wb_bus_arb_tmo #(.M(M), .S(S), .Dw(Dw), .Aw(Aw), .SELw(SELw), .TAGw(TAGw), .CTIw(CTIw),
                     .BTEw(BTEw), .ARB_MODE(ARB_RR), .TMO_CYC(TMO)) dut_rr (
        .clk(clk), .reset(reset),
        .m_adr_i_all(m_adr), .m_dat_i_all(m_dat), .m_sel_i_all(m_sel), .m_tag_i_all(m_tag),
        .m_cti_i_all(m_cti), .m_bte_i_all(m_bte), .m_we_i_all(m_we), .m_stb_i_all(m_stb),
        .m_cyc_i_all(m_cyc), .m_dat_o_all(r_m_dat), .m_ack_o_all(r_m_ack),
        .m_err_o_all(r_m_err), .m_rty_o_all(r_m_rty), .s_adr_o_all(r_s_adr),
        .s_dat_o_all(r_s_dat), .s_sel_o_all(r_s_sel), .s_tag_o_all(r_s_tag),
        .s_cti_o_all(r_s_cti), .s_bte_o_all(r_s_bte), .s_we_o_all(r_s_we),
        .s_cyc_o_all(r_s_cyc), .s_stb_o_all(r_s_stb), .s_dat_i_all(s_dat_i),
        .s_ack_i_all(s_ack), .s_err_i_all(s_err), .s_rty_i_all(s_rty),
        .m_grant_addr(r_gadr), .s_sel_one_hot(s_sel), .bus_err_o(r_berr),
        .bus_err_tmo_o(r_btmo), .bus_err_mst_o(r_emst), .bus_err_adr_o(r_eadr)
    );

    wb_bus_arb_tmo #(.M(M), .S(S), .Dw(Dw), .Aw(Aw), .SELw(SELw), .TAGw(TAGw), .CTIw(CTIw),
                     .BTEw(BTEw), .ARB_MODE(ARB_FIXED), .TMO_CYC(TMO)) dut_fx (
        .clk(clk), .reset(reset),
        .m_adr_i_all(m_adr), .m_dat_i_all(m_dat), .m_sel_i_all(m_sel), .m_tag_i_all(m_tag),
        .m_cti_i_all(m_cti), .m_bte_i_all(m_bte), .m_we_i_all(m_we), .m_stb_i_all(m_stb),
        .m_cyc_i_all(m_cyc), .m_dat_o_all(f_m_dat), .m_ack_o_all(f_m_ack),
        .m_err_o_all(f_m_err), .m_rty_o_all(f_m_rty), .s_adr_o_all(f_s_adr),
        .s_dat_o_all(f_s_dat), .s_sel_o_all(f_s_sel), .s_tag_o_all(f_s_tag),
        .s_cti_o_all(f_s_cti), .s_bte_o_all(f_s_bte), .s_we_o_all(f_s_we),
        .s_cyc_o_all(f_s_cyc), .s_stb_o_all(f_s_stb), .s_dat_i_all(s_dat_i),
        .s_ack_i_all(s_ack), .s_err_i_all(s_err), .s_rty_i_all(s_rty),
        .m_grant_addr(f_gadr), .s_sel_one_hot(s_sel), .bus_err_o(f_berr),
        .bus_err_tmo_o(f_btmo), .bus_err_mst_o(f_emst), .bus_err_adr_o(f_eadr)
    );

    typedef struct {
        logic [3:0] cyc, stb, sel, sack, serr;   // stimulus
        logic [3:0] e_gnt, e_sstb, e_mack, e_merr; // expected
        logic       e_scyc, e_berr;
    } vec_t;

    vec_t vt[16];
    vec_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [Aw-1:0] adr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [Dw-1:0] dat_of(input int i);
        return 32'hDEADBEEF + 32'(i);
    endfunction

    function automatic logic [Aw-1:0] gaddr(input logic [3:0] g);
        logic [Aw-1:0] a;
        a = '0;
        for (int i = 0; i < M; i++) if (g[i]) a = adr_of(i);
        return a;
    endfunction

    function automatic logic [Dw-1:0] gdat(input logic [3:0] g);
        logic [Dw-1:0] d;
        d = '0;
        for (int i = 0; i < M; i++) if (g[i]) d = dat_of(i);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic [3:0] sel,
                         input logic [3:0] ack, input logic [3:0] err);
        m_cyc = cyc; m_stb = stb; s_sel = sel; s_ack = ack; s_err = err;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < M; i++) begin
            m_adr[i*Aw +: Aw] = adr_of(i);
            m_dat[i*Dw +: Dw] = dat_of(i);
        end
        for (int j = 0; j < S; j++) s_dat_i[j*Dw +: Dw] = 32'hA000_0000 + 32'(j);
        m_sel = '1; m_tag = '0; m_cti = '0; m_bte = '0; m_we = '1; s_rty = '0;
        drive(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        //          cyc      stb      sel      sack     serr     gnt      sstb     mack     merr   scyc berr
        vt[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[1]  = '{4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[2]  = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vt[3]  = '{4'b0011, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vt[4]  = '{4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[5]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0};
        vt[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[7]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[8]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vt[9]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
        vt[10] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        vt[11] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vt[12] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[13] = '{4'b0010, 4'b0010, 4'b1000, 4'b0000, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0010, 1'b1, 1'b0};
        vt[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

        do_reset();
        @(negedge clk);
        chk("rst berr", {r_berr, r_btmo}, 2'b00);
        chk("rst emst", r_emst, 2'd0);
        chk("rst eadr", r_eadr, 32'h0);
        chk("rst scyc", r_s_cyc, 4'b0);

        // table: one vector per clock cycle, round-robin instance
        for (int i = 0; i < 16; i++) begin
            vec_t e;
            next_cyc();
            drive(vt[i].cyc, vt[i].stb, vt[i].sel, vt[i].sack, vt[i].serr);
            sbq.push_back(vt[i]);
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("v%0d gnt_addr", i), r_gadr, gaddr(e.e_gnt));
            chk($sformatf("v%0d s_dat2", i), r_s_dat[2*Dw +: Dw], gdat(e.e_gnt));
            chk($sformatf("v%0d s_stb", i), r_s_stb, e.e_sstb);
            chk($sformatf("v%0d s_cyc", i), r_s_cyc, {4{e.e_scyc}});
            chk($sformatf("v%0d m_ack", i), r_m_ack, e.e_mack);
            chk($sformatf("v%0d m_err", i), r_m_err, e.e_merr);
            chk($sformatf("v%0d bus_err", i), r_berr, e.e_berr);
        end

        // watchdog: master 2, slave 0 selected, never acks
        next_cyc();
        drive(4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000);   // IDLE cycle
        for (int k = 1; k <= 5; k++) begin
            next_cyc();
            @(negedge clk);
            chk($sformatf("tmo k%0d m_err", k), r_m_err, 4'b0000);
            chk($sformatf("tmo k%0d s_cyc", k), r_s_cyc, 4'b1111);
        end
        next_cyc();
        @(negedge clk);
        chk("tmo term m_err", r_m_err, 4'b0100);
        chk("tmo term s_cyc", r_s_cyc, 4'b0000);
        chk("tmo term s_stb", r_s_stb, 4'b0000);
        chk("tmo term berr", r_berr, 1'b1);
        chk("tmo term btmo", r_btmo, 1'b1);
        chk("tmo term emst", r_emst, 2'd2);
        chk("tmo term eadr", r_eadr, adr_of(2));
        next_cyc();
        @(negedge clk);
        chk("tmo own s_cyc", r_s_cyc, 4'b1111);
        chk("tmo own berr", r_berr, 1'b0);
        chk("tmo own btmo hold", r_btmo, 1'b1);
        // ack lands on the expiry cycle: the slave response wins
        repeat (3) next_cyc();
        next_cyc();
        drive(4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0000);
        @(negedge clk);
        chk("race m_ack", r_m_ack, 4'b0100);
        chk("race m_err", r_m_err, 4'b0000);
        next_cyc();
        drive(4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("race no term s_cyc", r_s_cyc, 4'b1111);
        chk("race no term m_err", r_m_err, 4'b0000);

        // fixed priority vs round-robin with masters 1 and 3
        do_reset();
        drive(4'b1010, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        next_cyc(); @(negedge clk);
        chk("arb t1 fx", f_gadr, adr_of(1));
        chk("arb t1 rr", r_gadr, adr_of(1));
        next_cyc(); drive(4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        next_cyc(); drive(4'b1010, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("arb t3 fx", f_gadr, adr_of(3));
        chk("arb t3 rr", r_gadr, adr_of(3));
        next_cyc(); drive(4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        next_cyc(); drive(4'b1010, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("arb t5 fx", f_gadr, adr_of(1));
        chk("arb t5 rr", r_gadr, adr_of(1));
        next_cyc(); drive(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        next_cyc(); drive(4'b1010, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        next_cyc(); @(negedge clk);
        chk("arb t8 fx", f_gadr, adr_of(1));
        chk("arb t8 rr", r_gadr, adr_of(3));

        // reset in the middle of a master-2 transfer
        do_reset();
        drive(4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000);
        next_cyc(); @(negedge clk);
        chk("mid s_stb", r_s_stb, 4'b0010);
        chk("mid s_dat", r_s_dat[1*Dw +: Dw], dat_of(2));
        chk("mid m_dat", r_m_dat[0 +: Dw], 32'hA000_0001);
        next_cyc();
        s_ack = 4'b0010;
        reset = 1'b0;
        #1;
        chk("rst mid s_cyc", r_s_cyc, 4'b0000);
        chk("rst mid s_stb", r_s_stb, 4'b0000);
        chk("rst mid m_ack", r_m_ack, 4'b0000);
        chk("rst mid gadr", r_gadr, 32'h0);
        chk("rst mid m_dat", r_m_dat, '0);
        chk("rst mid s_adr", r_s_adr, '0);
        next_cyc();
        reset = 1'b1;
        drive(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        next_cyc(); @(negedge clk);
        chk("post rst winner", r_gadr, adr_of(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
